// File: rtl/score4_pkg.sv
// ============================================================================
// Module      : score4_pkg
// Description : Types and constants shared by the score4 input controller and
//               the score4 game core: arbiter state encoding, move encoding,
//               button index map and a decoder from debounced button levels
//               to a single move.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score4_pkg;

    // Number of physical push-buttons handled by the input controller.
    localparam int unsigned NUM_BTNS  = 3;

    // Bit positions of each button inside the packed button vectors.
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_PUT   = 2;

    // Width of each debounce counter. Sized so that the largest legal
    // DEBOUNCE_CYCLES (2^20-1) never needs more than CNT_W bits.
    localparam int unsigned CNT_W     = 20;

    // Arbiter states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EMIT         = 2'd1,
        WAIT_RELEASE = 2'd2
    } arb_state_t;

    // Move requested from the game core.
    typedef enum logic [1:0] {
        MV_NONE  = 2'd0,
        MV_LEFT  = 2'd1,
        MV_RIGHT = 2'd2,
        MV_PUT   = 2'd3
    } move_t;

    // Map a vector of debounced levels to a move. Only a single active
    // button yields a move; no button or a chord of two or more buttons
    // yields MV_NONE, which the arbiter turns into a rejection.
    function automatic move_t decode_move(input logic [NUM_BTNS-1:0] lvl);
        move_t mv;
        mv = MV_NONE;
        case (lvl)
            3'b001:  mv = MV_LEFT;
            3'b010:  mv = MV_RIGHT;
            3'b100:  mv = MV_PUT;
            default: mv = MV_NONE;
        endcase
        return mv;
    endfunction

endpackage

`default_nettype wire

// File: rtl/move_input_ctrl_if.sv
// ============================================================================
// Module      : move_input_ctrl_if
// Description : Bundle between the board push-buttons / game core and the
//               move input controller.
//   btn_left   raw left button, asynchronous, active-high
//   btn_right  raw right button, asynchronous, active-high
//   btn_put    raw put button, asynchronous, active-high
//   game_over  synchronous, high once the game has ended
//   left       one-cycle move-left pulse
//   right      one-cycle move-right pulse
//   put        one-cycle place-token pulse
//   rejected   one-cycle pulse when a press is discarded
//   master : the side that drives the buttons and game_over (board/core)
//   slave  : the move input controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_input_ctrl_if;

    logic btn_left;
    logic btn_right;
    logic btn_put;
    logic game_over;
    logic left;
    logic right;
    logic put;
    logic rejected;

    modport master (
        output btn_left,
        output btn_right,
        output btn_put,
        output game_over,
        input  left,
        input  right,
        input  put,
        input  rejected
    );

    modport slave (
        input  btn_left,
        input  btn_right,
        input  btn_put,
        input  game_over,
        output left,
        output right,
        output put,
        output rejected
    );

endinterface

`default_nettype wire

// File: rtl/debounce.sv
// ============================================================================
// Module      : debounce
// Description : One push-button conditioner: SYNC_STAGES-deep synchroniser,
//               saturating stability counter, debounced level and a one-cycle
//               flag marking a 0->1 change of the debounced level.
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_raw  raw button input, asynchronous to clk
//   level    debounced button level
//   rise     high for one cycle after level goes 0->1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce
    import score4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn_raw,
    output logic      level,
    output logic      rise
);

    // Terminal count: the level flips on the edge where the counter
    // already holds this value and the input still differs, i.e. after
    // DEBOUNCE_CYCLES consecutive differing samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;

    always_comb begin
        // Synchroniser shifts the raw input in at bit 0; the oldest bit
        // is the only one the rest of the logic looks at.
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
        synced  = sync_q[SYNC_STAGES-1];

        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;

        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                // Stable long enough: accept the new level. The counter
                // clears here, so it can never run past CNT_LAST.
                level_d = synced;
                rise_d  = synced;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

`default_nettype wire

// File: rtl/move_input_ctrl.sv
// ============================================================================
// Module      : move_input_ctrl
// Description : Turns the three raw score4 push-buttons into clean one-cycle
//               move pulses for the game core. Each button is synchronised
//               and debounced; an arbiter emits exactly one pulse per
//               press-release cycle and rejects chords and put-after-game-
//               over presses.
//   clk   system clock (50 MHz)
//   rst   asynchronous active-low reset
//   bus   move_input_ctrl_if.slave: raw buttons and game_over in,
//         left/right/put/rejected pulses out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_input_ctrl
    import score4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    move_input_ctrl_if.slave bus
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_raw[BTN_LEFT]  = bus.btn_left;
    assign btn_raw[BTN_RIGHT] = bus.btn_right;
    assign btn_raw[BTN_PUT]   = bus.btn_put;

    // ------------------------------------------------------------------
    // Per-button synchroniser + debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
            debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_raw (btn_raw[i]),
                .level   (btn_level[i]),
                .rise    (btn_rise[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    arb_state_t state_q;
    arb_state_t state_d;
    move_t      emit_move;
    logic       left_q;
    logic       left_d;
    logic       right_q;
    logic       right_d;
    logic       put_q;
    logic       put_d;
    logic       rejected_q;
    logic       rejected_d;

    // The move is judged on the levels seen during EMIT, one cycle after
    // the first press, so a second button that debounces in the same
    // cycle as the first is caught as a chord.
    assign emit_move = decode_move(btn_level);

    always_comb begin
        state_d    = state_q;
        left_d     = 1'b0;
        right_d    = 1'b0;
        put_d      = 1'b0;
        rejected_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|btn_rise) begin
                    state_d = EMIT;
                end
            end

            EMIT: begin
                state_d = WAIT_RELEASE;
                case (emit_move)
                    MV_LEFT:  left_d  = 1'b1;
                    MV_RIGHT: right_d = 1'b1;
                    // Cursor moves stay legal after the game ends so the
                    // player can still browse the board; placing does not.
                    MV_PUT: begin
                        if (bus.game_over) begin
                            rejected_d = 1'b1;
                        end else begin
                            put_d      = 1'b1;
                        end
                    end
                    default:  rejected_d = 1'b1;
                endcase
            end

            WAIT_RELEASE: begin
                // Any press made while another button is still down is
                // swallowed here; only a full release re-arms the arbiter.
                if (btn_level == '0) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            put_q      <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            right_q    <= right_d;
            put_q      <= put_d;
            rejected_q <= rejected_d;
        end
    end

    assign bus.left     = left_q;
    assign bus.right    = right_q;
    assign bus.put      = put_q;
    assign bus.rejected = rejected_q;

endmodule

`default_nettype wire

// File: tb/tb_move_input_ctrl.sv
// ============================================================================
// Module      : tb_move_input_ctrl
// Description : Self-checking bench for move_input_ctrl with
//               DEBOUNCE_CYCLES=4, SYNC_STAGES=2. A behavioural model based
//               on stability run-lengths and a press/busy abstraction
//               predicts the four outputs on every clock edge; directed
//               scenarios add latency and pulse-count checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_input_ctrl;

    localparam int D = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    move_input_ctrl_if bus ();

    move_input_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 = left, 1 = right, 2 = put. exp_o = {left,right,put,rejected}.
    bit       sh_m   [3][S];
    bit       lvl_m  [3];
    bit       rise_m [3];
    bit       prev_m [3];
    int       run_m  [3];
    bit       pend_m;
    bit       busy_m;
    bit [3:0] exp_o;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < S; k++) sh_m[b][k] = 1'b0;
            lvl_m[b]  = 1'b0;
            rise_m[b] = 1'b0;
            prev_m[b] = 1'b0;
            run_m[b]  = 0;
        end
        pend_m = 1'b0;
        busy_m = 1'b0;
        exp_o  = 4'b0000;
    endtask

    task automatic model_edge();
        bit [2:0] raw;
        bit [3:0] e;
        bit       s;
        int       ones;
        raw = {bus.btn_put, bus.btn_right, bus.btn_left};
        e   = 4'b0000;
        // Arbitration uses the levels as they stood before this edge.
        if (pend_m) begin
            ones = int'(lvl_m[0]) + int'(lvl_m[1]) + int'(lvl_m[2]);
            if (ones != 1)           e = 4'b0001;
            else if (lvl_m[0])       e = 4'b1000;
            else if (lvl_m[1])       e = 4'b0100;
            else if (bus.game_over)  e = 4'b0001;
            else                     e = 4'b0010;
            pend_m = 1'b0;
            busy_m = 1'b1;
        end else if (busy_m) begin
            if (!(lvl_m[0] || lvl_m[1] || lvl_m[2])) busy_m = 1'b0;
        end else if (rise_m[0] || rise_m[1] || rise_m[2]) begin
            pend_m = 1'b1;
        end
        // Debounce: a level follows the synchronised value once that value
        // has been seen differing on D consecutive edges.
        for (int b = 0; b < 3; b++) begin
            s = sh_m[b][S-1];
            if (s == prev_m[b]) run_m[b]++;
            else                run_m[b] = 1;
            prev_m[b] = s;
            rise_m[b] = 1'b0;
            if (s != lvl_m[b] && run_m[b] >= D) begin
                lvl_m[b]  = s;
                rise_m[b] = s;
            end
            for (int k = S - 1; k > 0; k--) sh_m[b][k] = sh_m[b][k-1];
            sh_m[b][0] = raw[b];
        end
        exp_o = e;
    endtask

    // ---------------- cycle stepping ----------------
    int c_l, c_r, c_p, c_j;
    int edge_no;
    int put_edge;

    task automatic clr_counts();
        c_l = 0; c_r = 0; c_p = 0; c_j = 0;
        edge_no = 0;
        put_edge = -1;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_eq("outputs", {28'd0, bus.left, bus.right, bus.put, bus.rejected}, {28'd0, exp_o});
        edge_no++;
        c_l += int'(bus.left);
        c_r += int'(bus.right);
        c_p += int'(bus.put);
        c_j += int'(bus.rejected);
        if (bus.put && put_edge < 0) put_edge = edge_no;
    endtask

    task automatic release_all(input int n);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_put   = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_put   = 1'b0;
        bus.game_over = 1'b0;
        model_reset();
        clr_counts();

        // Reset state
        repeat (3) step();
        check_eq("reset_quiet", c_l + c_r + c_p + c_j, 0);
        rst = 1'b1;
        release_all(8);

        // Single put press: one pulse, 8 edges after first sampling edge
        clr_counts();
        bus.btn_put = 1'b1;
        repeat (20) step();
        release_all(12);
        check_eq("put_latency", put_edge, 8);
        check_eq("put_count", c_p, 1);
        check_eq("put_others", c_l + c_r + c_j, 0);

        // Short glitches never reach the outputs
        clr_counts();
        repeat (5) begin
            bus.btn_right = 1'b1;
            repeat (3) step();
            bus.btn_right = 1'b0;
            step();
        end
        release_all(12);
        check_eq("glitch_none", c_l + c_r + c_p + c_j, 0);

        // Left then right two cycles later: left wins, right ignored
        clr_counts();
        bus.btn_left = 1'b1;
        repeat (2) step();
        bus.btn_right = 1'b1;
        repeat (20) step();
        release_all(12);
        check_eq("stagger_left", c_l, 1);
        check_eq("stagger_right", c_r, 0);
        clr_counts();
        bus.btn_right = 1'b1;
        repeat (10) step();
        release_all(12);
        check_eq("fresh_right", c_r, 1);

        // Simultaneous chord: rejected once; arbiter waits for full release
        clr_counts();
        bus.btn_left = 1'b1;
        bus.btn_put  = 1'b1;
        repeat (15) step();
        bus.btn_left = 1'b0;
        repeat (10) step();
        bus.btn_right = 1'b1;
        repeat (10) step();
        release_all(12);
        check_eq("chord_reject", c_j, 1);
        check_eq("chord_moves", c_l + c_r + c_p, 0);

        // game_over: put rejected, left still allowed
        bus.game_over = 1'b1;
        clr_counts();
        bus.btn_put = 1'b1;
        repeat (15) step();
        release_all(12);
        check_eq("go_put_reject", c_j, 1);
        check_eq("go_put_none", c_p, 0);
        clr_counts();
        bus.btn_left = 1'b1;
        repeat (15) step();
        release_all(12);
        check_eq("go_left", c_l, 1);
        check_eq("go_left_noreject", c_j, 0);
        bus.game_over = 1'b0;

        // Reset mid-debounce with put held; exactly one pulse after release
        clr_counts();
        bus.btn_put = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("rst_mid_debounce", {28'd0, bus.left, bus.right, bus.put, bus.rejected}, 32'd0);
        repeat (2) step();
        rst = 1'b1;
        clr_counts();
        repeat (20) step();
        release_all(12);
        check_eq("rst_put_latency", put_edge, 8);
        check_eq("rst_put_count", c_p, 1);

        // Reset asserted while a pulse is on the output
        clr_counts();
        bus.btn_put = 1'b1;
        for (int i = 0; i < 20 && !bus.put; i++) step();
        check_eq("pulse_seen", {31'd0, bus.put}, 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("rst_kills_pulse", {28'd0, bus.left, bus.right, bus.put, bus.rejected}, 32'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (15) step();
        release_all(12);

        // Randomised patterns checked cycle by cycle against the model
        clr_counts();
        repeat (200) begin
            int hold;
            bit [2:0] pat;
            bus.game_over = ($urandom_range(0, 3) == 0);
            pat = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom);
            bus.btn_left  = pat[0];
            bus.btn_right = pat[1];
            bus.btn_put   = pat[2];
            hold = $urandom_range(1, 14);
            repeat (hold) step();
        end
        release_all(12);
        check_eq("random_activity", {31'd0, (c_l + c_r + c_p + c_j) > 0}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
